// File: rtl/mem_pkg.sv
// mem_pkg: shared size codes, FSM states and helpers for the data memory responder
package mem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  // Reserved size or a lane offset that does not match the access size
  function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lane);
    return (size == SIZE_RSVD) || (size == SIZE_HALF && lane[0]) || (size == SIZE_WORD && lane != 2'd0);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian byte enables, store merge and load extension for one word
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);
  logic [31:0] w_rep;
  logic [31:0] w_shift;
  // Replicate store data across lanes, merge enabled lanes, shift and extend the load lane
  always_comb begin
    o_be = i_size == SIZE_BYTE ? 4'b0001 << i_lane :
           i_size == SIZE_HALF ? (i_lane[1] ? 4'b1100 : 4'b0011) :
           i_size == SIZE_WORD ? 4'b1111 : 4'b0000;
    w_rep = i_size == SIZE_BYTE ? {4{i_wdata[7:0]}} : i_size == SIZE_HALF ? {2{i_wdata[15:0]}} : i_wdata;
    for (int b = 0; b < 4; b++) o_wword[8*b +: 8] = o_be[b] ? w_rep[8*b +: 8] : i_old[8*b +: 8];
    w_shift = i_old >> {i_lane, 3'b000};
    o_rdata = i_size == SIZE_BYTE ? {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]} :
              i_size == SIZE_HALF ? {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]} : i_old;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with programmable wait states
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic             r_uns;
  logic [1:0]       r_size;
  logic [AW-1:0]    r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_mem [2**ADDR_WIDTH];
  logic             w_idle;
  logic             w_err;
  logic             w_acc;
  logic             w_we;
  logic             w_uns;
  logic [1:0]       w_size;
  logic [AW-1:0]    w_addr;
  logic [31:0]      w_wdata;
  logic [31:0]      w_old;
  logic [31:0]      w_wword;
  logic [31:0]      w_ld;
  logic [3:0]       w_be;
  assign w_idle    = r_state == IDLE;
  assign req_ready = w_idle;
  assign busy      = ~w_idle;
  assign w_err     = bad_align(req_size, req_addr[1:0]) || (req_addr[31:AW] != '0);
  // With zero wait states the access happens at acceptance, so it must use the live request
  assign w_we      = w_idle ? req_we : r_we;
  assign w_uns     = w_idle ? req_unsigned : r_uns;
  assign w_size    = w_idle ? req_size : r_size;
  assign w_addr    = w_idle ? req_addr[AW-1:0] : r_addr;
  assign w_wdata   = w_idle ? req_wdata : r_wdata;
  assign w_acc     = w_idle ? (req_valid && !w_err && WAIT_CYCLES == 0) : (r_state == WAIT && r_cnt == '0);
  assign w_old     = r_mem[w_addr[AW-1:2]];
  mem_lane_align u_align (
    .i_size    (w_size),
    .i_lane    (w_addr[1:0]),
    .i_unsigned(w_uns),
    .i_old     (w_old),
    .i_wdata   (w_wdata),
    .o_be      (w_be),
    .o_wword   (w_wword),
    .o_rdata   (w_ld)
  );
  // Byte-enabled store commit; gated by rst so nothing is written while held in reset
  always_ff @(posedge clk) begin
    if (rst && w_acc && w_we)
      for (int b = 0; b < 4; b++) if (w_be[b]) r_mem[w_addr[AW-1:2]][8*b +: 8] <= w_wword[8*b +: 8];
  end
  // Request FSM: accept and classify in IDLE, count wait states, pulse the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_size  <= req_size;
            r_addr  <= req_addr[AW-1:0];
            r_wdata <= req_wdata;
            if (w_err || WAIT_CYCLES == 0) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= w_err;
              resp_rdata <= (w_err || req_we) ? '0 : w_ld;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= r_we ? '0 : w_ld;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state    <= IDLE;
          resp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of two responders against a byte-array model
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic a_valid, a_ready, a_we, a_uns, a_rv, a_err, a_busy;
  logic b_valid, b_ready, b_we, b_uns, b_rv, b_err, b_busy;
  logic [1:0] a_size, b_size;
  logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_size(a_size),
    .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_rv),
    .resp_rdata(a_rdata), .resp_err(a_err), .busy(a_busy)
  );
  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_size(b_size),
    .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_rv),
    .resp_rdata(b_rdata), .resp_err(b_err), .busy(b_busy)
  );
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mdl [2][4096];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
    return size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0) || addr >= 32'd4096;
  endfunction

  function automatic logic [31:0] ref_load(input int d, input logic [1:0] size, input bit uns, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    v = 0;
    n = 1 << size;
    for (int i = 0; i < n; i++) v |= 32'(mdl[d][addr + i]) << (8 * i);
    if (!uns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic logic o_rv(input int d);    return d != 0 ? b_rv : a_rv;       endfunction
  function automatic logic o_err(input int d);   return d != 0 ? b_err : a_err;     endfunction
  function automatic logic o_ready(input int d); return d != 0 ? b_ready : a_ready; endfunction
  function automatic logic o_busy(input int d);  return d != 0 ? b_busy : a_busy;   endfunction
  function automatic logic [31:0] o_rd(input int d); return d != 0 ? b_rdata : a_rdata; endfunction

  task automatic drive(input int d, input bit v, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (d != 0) begin
      b_valid = v; b_we = we; b_size = size; b_uns = uns; b_addr = addr; b_wdata = wdata;
    end else begin
      a_valid = v; a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic xact(input int d, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rd);
    bit e;
    logic [31:0] exp;
    int lat;
    int cyc;
    bit got;
    e = ref_err(size, addr);
    exp = (e || we) ? 32'd0 : ref_load(d, size, uns, addr);
    lat = e ? 1 : (d != 0 ? 1 : 3);
    cyc = 0;
    got = 0;
    @(negedge clk);
    drive(d, 1, we, size, uns, addr, wdata);
    check("accept_ready", o_ready(d), 1);
    @(posedge clk);
    #1 drive(d, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (o_rv(d)) got = 1;
      else check("busy_while_pending", o_busy(d), 1);
    end
    check("latency", cyc, lat);
    check("resp_err", o_err(d), e);
    check("resp_rdata", o_rd(d), exp);
    rd = o_rd(d);
    @(negedge clk);
    check("resp_one_cycle", o_rv(d), 0);
    check("back_to_idle", o_ready(d), 1);
    if (we && !e) for (int i = 0; i < (1 << size); i++) mdl[d][addr + i] = wdata[8*i +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    int nr, nv;
    drive(0, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    drive(1, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_valid_a", a_rv, 0);
    check("rst_rdata_a", a_rdata, 0);
    check("rst_err_a", a_err, 0);
    check("rst_valid_b", b_rv, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready_a", a_ready, 1);
    check("rel_busy_a", a_busy, 0);
    check("rel_ready_b", b_ready, 1);
    // store then load a word
    xact(0, 1, 2'd2, 0, 32'h10, 32'h12345678, rd);
    check("sw_rdata_zero", rd, 32'h0);
    xact(0, 0, 2'd2, 0, 32'h10, 32'h0, rd);
    check("lw_10", rd, 32'h12345678);
    // sub-word loads and a byte store
    xact(0, 0, 2'd0, 0, 32'h13, 32'h0, rd);
    check("lb_13", rd, 32'h00000012);
    xact(0, 0, 2'd0, 1, 32'h13, 32'h0, rd);
    check("lbu_13", rd, 32'h00000012);
    xact(0, 0, 2'd1, 0, 32'h12, 32'h0, rd);
    check("lh_12", rd, 32'h00001234);
    xact(0, 1, 2'd0, 0, 32'h11, 32'h000000AB, rd);
    xact(0, 0, 2'd2, 0, 32'h10, 32'h0, rd);
    check("lw_after_sb", rd, 32'h1234AB78);
    xact(0, 0, 2'd0, 0, 32'h11, 32'h0, rd);
    check("lb_11", rd, 32'hFFFFFFAB);
    xact(0, 0, 2'd0, 1, 32'h11, 32'h0, rd);
    check("lbu_11", rd, 32'h000000AB);
    // error classes, including stores that must not land
    xact(0, 0, 2'd2, 0, 32'h12, 32'h0, rd);
    xact(0, 0, 2'd1, 0, 32'h11, 32'h0, rd);
    xact(0, 1, 2'd3, 0, 32'h10, 32'hFFFFFFFF, rd);
    xact(0, 1, 2'd2, 0, 32'h1010, 32'hFFFFFFFF, rd);
    xact(0, 1, 2'd2, 0, 32'h12, 32'hFFFFFFFF, rd);
    xact(0, 0, 2'd2, 0, 32'h10, 32'h0, rd);
    check("lw_after_errors", rd, 32'h1234AB78);
    // request held continuously: one acceptance every four cycles
    nr = 0;
    nv = 0;
    @(negedge clk);
    drive(0, 1, 0, 2'd2, 0, 32'h10, 32'h0);
    for (int k = 0; k < 16; k++) begin
      if (a_ready) nr++;
      if (a_rv) begin
        nv++;
        check("b2b_rdata", a_rdata, ref_load(0, 2'd2, 0, 32'h10));
      end
      @(negedge clk);
    end
    drive(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    check("b2b_accepts", nr, 4);
    check("b2b_resps", nv, 4);
    // reset during the wait of a store aborts it
    xact(0, 1, 2'd2, 0, 32'h20, 32'h0, rd);
    xact(0, 0, 2'd2, 0, 32'h10, 32'h0, rd);
    @(negedge clk);
    drive(0, 1, 1, 2'd2, 0, 32'h20, 32'hDEADBEEF);
    @(posedge clk);
    #1 drive(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("abort_busy", a_busy, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rdata", a_rdata, 0);
    check("async_valid", a_rv, 0);
    check("async_ready", a_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    xact(0, 0, 2'd2, 0, 32'h20, 32'h0, rd);
    check("abort_no_commit", rd, 32'h0);
    // zero wait states
    xact(1, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, rd);
    xact(1, 0, 2'd2, 0, 32'h40, 32'h0, rd);
    check("w0_lw_40", rd, 32'hCAFEF00D);
    xact(1, 0, 2'd1, 0, 32'h42, 32'h0, rd);
    check("w0_lh_42", rd, 32'hFFFFCAFE);
    // random traffic over an initialised window plus illegal accesses
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) xact(d, 1, 2'd2, 0, 32'(w * 4), $urandom, rd);
    for (int n = 0; n < 120; n++) begin
      int d;
      logic [1:0] sz;
      logic [31:0] ad;
      d = int'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 63));
      xact(d, bit'($urandom_range(0, 1)), sz, bit'($urandom_range(0, 1)), ad, $urandom, rd);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
